// File: rtl/snake_body_tracer.sv
// Walks a snake body back from the head through the move history, streaming one segment per cycle.
// Optional TRACER_SELF_HIT_EN enables head-collision detection on self_hit.
module snake_body_tracer #(
    parameter int GRID_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [GRID_BITS-1:0] head_x,
    input  logic [GRID_BITS-1:0] head_y,
    input  logic [5:0]           length,
    input  logic [GRID_BITS-1:0] query_x,
    input  logic [GRID_BITS-1:0] query_y,
    input  logic [2:0]           dir_in,
    output logic [5:0]           pos,
    output logic                 busy,
    output logic                 seg_valid,
    output logic [GRID_BITS-1:0] seg_x,
    output logic [GRID_BITS-1:0] seg_y,
    output logic                 done,
    output logic                 hit,
    output logic                 self_hit
);

    localparam logic [GRID_BITS-1:0] ONE = GRID_BITS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [GRID_BITS-1:0] hx_q, hy_q, qx_q, qy_q;
    logic [GRID_BITS-1:0] px_q, py_q;
    logic [GRID_BITS-1:0] tx, ty;
    logic [5:0]           len_q, pos_q;
    logic                 hit_q;
    logic                 accept;
    logic                 q_match;

    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (length == 6'd0) ? FIN : WALK;
            WALK: if (pos_q == len_q - 6'd1) state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Undo the recorded move: previous segment minus that move's displacement.
    always_comb begin
        tx = px_q;
        ty = py_q;
        case (dir_in)
            3'b001: ty = py_q + ONE;
            3'b010: ty = py_q - ONE;
            3'b011: tx = px_q + ONE;
            3'b100: tx = px_q - ONE;
            default: ;
        endcase
    end

    assign seg_valid = (state == WALK);
    assign busy      = (state == WALK);
    assign done      = (state == FIN);
    assign pos       = pos_q;

    always_comb begin
        seg_x = '0;
        seg_y = '0;
        if (seg_valid) begin
            seg_x = (pos_q == 6'd0) ? hx_q : tx;
            seg_y = (pos_q == 6'd0) ? hy_q : ty;
        end
    end

    assign q_match = seg_valid && (seg_x == qx_q) && (seg_y == qy_q);
    assign hit     = hit_q | q_match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hx_q  <= '0;
            hy_q  <= '0;
            qx_q  <= '0;
            qy_q  <= '0;
            len_q <= '0;
            px_q  <= '0;
            py_q  <= '0;
            pos_q <= '0;
            hit_q <= 1'b0;
        end else if (accept) begin
            hx_q  <= head_x;
            hy_q  <= head_y;
            qx_q  <= query_x;
            qy_q  <= query_y;
            len_q <= length;
            pos_q <= '0;
            hit_q <= 1'b0;
        end else if (state == WALK) begin
            px_q  <= seg_x;
            py_q  <= seg_y;
            pos_q <= (state_nx == WALK) ? pos_q + 6'd1 : 6'd0;
            hit_q <= hit;
        end
    end

`ifdef TRACER_SELF_HIT_EN
    logic self_q;
    logic h_match;

    assign h_match  = seg_valid && (pos_q != 6'd0) && (seg_x == hx_q) && (seg_y == hy_q);
    assign self_hit = self_q | h_match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              self_q <= 1'b0;
        else if (accept)         self_q <= 1'b0;
        else if (state == WALK)  self_q <= self_hit;
    end
`else
    assign self_hit = 1'b0;
`endif

endmodule

// File: tb/tb_snake_body_tracer.sv
// Self-checking bench for snake_body_tracer: directed table, hand-written corner sequences, random traces.
module tb_snake_body_tracer;

`ifdef TRACER_SELF_HIT_EN
    localparam bit SH_EN = 1'b1;
`else
    localparam bit SH_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] head_x, head_y, query_x, query_y;
    logic [5:0] length;
    logic [2:0] dir_in = 3'd0;
    logic [5:0] pos;
    logic       busy, seg_valid, done, hit, self_hit;
    logic [3:0] seg_x, seg_y;

    logic [2:0] hist [64];
    int tests = 0;
    int fails = 0;

    snake_body_tracer #(.GRID_BITS(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .head_x(head_x), .head_y(head_y), .length(length),
        .query_x(query_x), .query_y(query_y), .dir_in(dir_in),
        .pos(pos), .busy(busy), .seg_valid(seg_valid),
        .seg_x(seg_x), .seg_y(seg_y), .done(done),
        .hit(hit), .self_hit(self_hit)
    );

    always #5 clk = ~clk;

    // Move-register model: the entry for pos appears on dir_in one cycle later.
    always @(posedge clk) dir_in <= hist[pos];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " seg_valid"}, int'(seg_valid), 0);
        chk({tag, " pos"}, int'(pos), 0);
        chk({tag, " busy"}, int'(busy), 0);
        chk({tag, " done"}, int'(done), 0);
    endtask

    function automatic void disp(input logic [2:0] d, output int dx, output int dy);
        dx = 0; dy = 0;
        if (d == 3'd1) dy = -1;
        else if (d == 3'd2) dy = 1;
        else if (d == 3'd3) dx = -1;
        else if (d == 3'd4) dx = 1;
    endfunction

    // Runs one trace against a coordinate-list model; extra_k >= 0 fires a junk start at that segment.
    task automatic run_trace(input int hx, input int hy, input int len, input int qx, input int qy,
                             input int extra_k,
                             output int lx, output int ly, output int hit_d, output int self_d);
        int ex[64];
        int ey[64];
        int dx, dy;
        int eh, es;
        ex[0] = hx; ey[0] = hy;
        for (int k = 1; k < len; k++) begin
            disp(hist[k-1], dx, dy);
            ex[k] = (ex[k-1] - dx) & 15;
            ey[k] = (ey[k-1] - dy) & 15;
        end
        lx = -1; ly = -1;
        @(negedge clk);
        start = 1'b1;
        head_x = 4'(hx); head_y = 4'(hy); length = 6'(len);
        query_x = 4'(qx); query_y = 4'(qy);
        @(negedge clk);
        start = 1'b0;
        eh = 0; es = 0;
        for (int k = 0; k < len; k++) begin
            if (ex[k] == qx && ey[k] == qy) eh = 1;
            if (SH_EN && k >= 1 && ex[k] == hx && ey[k] == hy) es = 1;
            chk("walk seg_valid", int'(seg_valid), 1);
            chk("walk busy", int'(busy), 1);
            chk("walk done", int'(done), 0);
            chk("walk pos", int'(pos), k);
            chk("walk seg_x", int'(seg_x), ex[k]);
            chk("walk seg_y", int'(seg_y), ey[k]);
            chk("walk hit", int'(hit), eh);
            chk("walk self_hit", int'(self_hit), es);
            lx = int'(seg_x); ly = int'(seg_y);
            if (k == extra_k) begin
                start = 1'b1;
                head_x = 4'(hx + 3); head_y = 4'(hy + 7); length = 6'd1;
                query_x = 4'(qx + 1); query_y = 4'(qy + 1);
            end
            @(negedge clk);
            start = 1'b0;
        end
        chk("fin done", int'(done), 1);
        chk("fin busy", int'(busy), 0);
        chk("fin seg_valid", int'(seg_valid), 0);
        chk("fin pos", int'(pos), 0);
        chk("fin hit", int'(hit), eh);
        chk("fin self_hit", int'(self_hit), es);
        hit_d = int'(hit); self_d = int'(self_hit);
        @(negedge clk);
        chk_quiet("post");
        chk("post hit held", int'(hit), eh);
    endtask

    typedef struct {
        int hx, hy, len, qx, qy;
        logic [2:0] d [4];
        int lx, ly, hit, sh;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int lx, ly, hd, sd;
        int hx, hy, len, qx, qy, pick;
        int ex, ey, dx, dy;

        for (int i = 0; i < 64; i++) hist[i] = 3'd0;
        start = 1'b0; head_x = '0; head_y = '0; length = '0; query_x = '0; query_y = '0;
        reset = 1'b0;
        #3;
        chk_quiet("reset");
        chk("reset seg_x", int'(seg_x), 0);
        chk("reset seg_y", int'(seg_y), 0);
        chk("reset hit", int'(hit), 0);
        chk("reset self_hit", int'(self_hit), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        vecs[0] = '{hx:5, hy:5, len:4, qx:9,  qy:9, d:'{3'd4, 3'd4, 3'd2, 3'd0}, lx:3,  ly:4,  hit:0, sh:0};
        vecs[1] = '{hx:0, hy:0, len:3, qx:15, qy:0, d:'{3'd4, 3'd2, 3'd0, 3'd0}, lx:15, ly:15, hit:1, sh:0};
        vecs[2] = '{hx:2, hy:2, len:2, qx:2,  qy:3, d:'{3'd1, 3'd0, 3'd0, 3'd0}, lx:2,  ly:3,  hit:1, sh:0};
        vecs[3] = '{hx:4, hy:4, len:5, qx:7,  qy:7, d:'{3'd1, 3'd3, 3'd2, 3'd4}, lx:4,  ly:4,  hit:0, sh:int'(SH_EN)};

        for (int v = 0; v < 4; v++) begin
            for (int j = 0; j < 4; j++) hist[j] = vecs[v].d[j];
            run_trace(vecs[v].hx, vecs[v].hy, vecs[v].len, vecs[v].qx, vecs[v].qy, -1, lx, ly, hd, sd);
            chk("table last_x", lx, vecs[v].lx);
            chk("table last_y", ly, vecs[v].ly);
            chk("table hit", hd, vecs[v].hit);
            chk("table self_hit", sd, vecs[v].sh);
            if (v == 2) begin
                repeat (3) @(negedge clk);
                chk("hit sticky idle", int'(hit), 1);
            end
        end

        // length 0: done straight away, no segments
        @(negedge clk);
        start = 1'b1; length = 6'd0; head_x = 4'd1; head_y = 4'd1; query_x = 4'd1; query_y = 4'd1;
        @(negedge clk);
        start = 1'b0;
        chk("len0 done", int'(done), 1);
        chk("len0 seg_valid", int'(seg_valid), 0);
        chk("len0 busy", int'(busy), 0);
        chk("len0 hit", int'(hit), 0);
        @(negedge clk);
        chk_quiet("len0 after");

        // length 10 with an ignored start mid-trace
        for (int i = 0; i < 10; i++) hist[i] = 3'(1 + (i % 4));
        run_trace(7, 3, 10, 0, 0, 4, lx, ly, hd, sd);
        repeat (3) begin
            @(negedge clk);
            chk_quiet("len10 tail");
        end

        // reset at segment 3 of a length-8 trace
        for (int i = 0; i < 8; i++) hist[i] = 3'd4;
        @(negedge clk);
        start = 1'b1; length = 6'd8; head_x = 4'd6; head_y = 4'd6; query_x = 4'd6; query_y = 4'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset pos", int'(pos), 3);
        reset = 1'b0;
        #1;
        chk_quiet("midreset");
        chk("midreset seg_x", int'(seg_x), 0);
        chk("midreset seg_y", int'(seg_y), 0);
        chk("midreset hit", int'(hit), 0);
        chk("midreset self_hit", int'(self_hit), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk_quiet("after reset");
        end
        hist[0] = 3'd3; hist[1] = 3'd1;
        run_trace(8, 8, 3, 9, 9, -1, lx, ly, hd, sd);
        chk("post-reset hit", hd, 1);

        // randomized traces; half aim the query at a real segment
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < 64; i++) hist[i] = 3'($urandom_range(0, 7));
            hx = $urandom_range(0, 15); hy = $urandom_range(0, 15);
            len = $urandom_range(0, 20);
            qx = $urandom_range(0, 15); qy = $urandom_range(0, 15);
            if (len > 0 && $urandom_range(0, 1) == 1) begin
                pick = $urandom_range(0, len - 1);
                ex = hx; ey = hy;
                for (int k = 1; k <= pick; k++) begin
                    disp(hist[k-1], dx, dy);
                    ex = (ex - dx) & 15;
                    ey = (ey - dy) & 15;
                end
                qx = ex; qy = ey;
            end
            if (len == 0) begin
                @(negedge clk);
                start = 1'b1; length = 6'd0; head_x = 4'(hx); head_y = 4'(hy);
                query_x = 4'(qx); query_y = 4'(qy);
                @(negedge clk);
                start = 1'b0;
                chk("rnd len0 done", int'(done), 1);
                chk("rnd len0 hit", int'(hit), 0);
                chk("rnd len0 seg_valid", int'(seg_valid), 0);
            end else begin
                run_trace(hx, hy, len, qx, qy, (t % 3 == 0) ? $urandom_range(0, len - 1) : -1,
                          lx, ly, hd, sd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
